multicycle_controller: RTL and testbench

- Sequencing FSM for the multicycle RV64I core variant.
- Replaces the single-cycle combinational control path. Steps the shared datapath (one ALU, one unified memory port, IR/oldPC/ALUOut/MDR registers) through fetch, decode, execute, memory and writeback.
- Talks to variable-latency memory over a req/ready handshake.
- The existing ALU decoder and branch unit remain combinational helpers. This block owns timing and enables.

---
 rtl/multicycle_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV64I core: steps the shared datapath through
// fetch/decode/execute/memory/writeback and handshakes with variable-latency memory.
module multicycle_controller #(
    parameter int RESET_WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_bit5,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write_en,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       reg_write_en,
    output logic [2:0] imm_src,
    output logic [1:0] mem_size,
    output logic       mem_unsigned,
    output logic       word_op,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_RESET_WAIT = 4'd0,
        S_FETCH      = 4'd1,
        S_DECODE     = 4'd2,
        S_EXEC_R     = 4'd3,
        S_EXEC_I     = 4'd4,
        S_ALU_WB     = 4'd5,
        S_MEM_ADDR   = 4'd6,
        S_MEM_RD     = 4'd7,
        S_MEM_WB     = 4'd8,
        S_MEM_WR     = 4'd9,
        S_BRANCH     = 4'd10,
        S_JAL        = 4'd11,
        S_JALR       = 4'd12,
        S_JALR_LINK  = 4'd13,
        S_HALT       = 4'd14
    } state_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wait_cnt;
    logic       r_illegal;
    logic       w_dec_illegal;
    logic [2:0] w_imm_op;
    logic       w_is_word;
    logic       w_unused_f7;

    // funct7[5] is consumed by the ALU decoder, not by the sequencer.
    assign w_unused_f7 = funct7_bit5;
    assign w_is_word   = (opcode == OPC_OP_32) || (opcode == OPC_OP_IMM32);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RESET_WAIT;
            r_wait_cnt <= 4'd0;
            r_illegal  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_RESET_WAIT && w_next == S_RESET_WAIT)
                r_wait_cnt <= r_wait_cnt + 4'd1;
            if (w_dec_illegal)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_dec_illegal = 1'b0;
        case (r_state)
            S_RESET_WAIT: if (r_wait_cnt == 4'(RESET_WAIT_CYCLES - 1)) w_next = S_FETCH;
            S_FETCH:      if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE:                          w_next = S_MEM_ADDR;
                    OPC_OP, OPC_OP_32:                            w_next = S_EXEC_R;
                    OPC_OP_IMM, OPC_OP_IMM32, OPC_LUI, OPC_AUIPC: w_next = S_EXEC_I;
                    OPC_BRANCH:                                   w_next = S_BRANCH;
                    OPC_JAL:                                      w_next = S_JAL;
                    OPC_JALR:                                     w_next = S_JALR;
                    OPC_FENCE:                                    w_next = S_FETCH;
                    OPC_SYSTEM:                                   w_next = S_HALT;
                    default: begin
                        w_next        = S_HALT;
                        w_dec_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_JAL: w_next = S_ALU_WB;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JALR_LINK: w_next = S_FETCH;
            S_MEM_ADDR:   w_next = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:     if (mem_ready) w_next = S_MEM_WB;
            S_MEM_WR:     if (mem_ready) w_next = S_FETCH;
            S_JALR:       w_next = S_JALR_LINK;
            S_HALT:       w_next = S_HALT;
            default:      w_next = S_HALT;
        endcase
    end

    always_comb begin
        case (opcode)
            OPC_STORE:          w_imm_op = IMM_S;
            OPC_BRANCH:         w_imm_op = IMM_B;
            OPC_LUI, OPC_AUIPC: w_imm_op = IMM_U;
            OPC_JAL:            w_imm_op = IMM_J;
            default:            w_imm_op = IMM_I;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_write_en = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        result_src   = 2'b00;
        reg_write_en = 1'b0;
        imm_src      = w_imm_op;
        mem_size     = 2'b00;
        mem_unsigned = 1'b0;
        word_op      = 1'b0;
        case (r_state)
            S_RESET_WAIT, S_HALT: imm_src = 3'b000;
            S_FETCH: begin
                imm_src    = 3'b000;
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            // Branch target is precomputed here so BRANCH only needs the compare.
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = IMM_B;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                word_op   = w_is_word;
            end
            S_EXEC_I: begin
                alu_src_b = 2'b01;
                word_op   = w_is_word;
                if (opcode == OPC_LUI) begin
                    alu_op = 2'b11;
                end else if (opcode == OPC_AUIPC) begin
                    alu_src_a = 2'b01;
                end else begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
            end
            S_ALU_WB: reg_write_en = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEM_RD: begin
                mem_req      = 1'b1;
                adr_src      = 1'b1;
                mem_size     = funct3[1:0];
                mem_unsigned = funct3[2];
            end
            S_MEM_WB: begin
                result_src   = 2'b01;
                reg_write_en = 1'b1;
                mem_size     = funct3[1:0];
                mem_unsigned = funct3[2];
            end
            S_MEM_WR: begin
                mem_req      = 1'b1;
                mem_write_en = 1'b1;
                adr_src      = 1'b1;
                mem_size     = funct3[1:0];
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = branch_taken;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            S_JALR_LINK: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                reg_write_en = 1'b1;
            end
            default: imm_src = 3'b000;
        endcase
    end

    assign halted  = (r_state == S_HALT);
    assign illegal = r_illegal;
    assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction cycle recipes
// drive a scoreboard queue compared against the DUT every cycle.
module tb_multicycle_controller;

    localparam int RWC = 1;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write_en;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic [1:0] res;
        logic       rwe;
        logic [2:0] imm;
        logic [1:0] msize;
        logic       muns;
        logic       word;
        logic       halted;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       rdy;
        logic       tk;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_bit5 = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write_en, adr_src, ir_write, pc_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       reg_write_en;
    logic [2:0] imm_src;
    logic [1:0] mem_size;
    logic       mem_unsigned, word_op, halted, illegal;
    logic [3:0] state_o;

    outs_t act;
    vec_t  q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.RESET_WAIT_CYCLES(RWC)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7_bit5(funct7_bit5), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write_en(mem_write_en), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .reg_write_en(reg_write_en), .imm_src(imm_src), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .word_op(word_op), .halted(halted),
        .illegal(illegal), .state_o(state_o)
    );

    assign act = {mem_req, mem_write_en, adr_src, ir_write, pc_write, alu_src_a,
                  alu_src_b, alu_op, result_src, reg_write_en, imm_src, mem_size,
                  mem_unsigned, word_op, halted, illegal};

    task automatic check(input string nm, input outs_t e);
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, e);
        end
    endtask

    task automatic push(input logic [6:0] op, input logic [2:0] f3, input logic rdy,
                        input logic tk, input outs_t o);
        vec_t v;
        v.op = op; v.f3 = f3; v.rdy = rdy; v.tk = tk; v.exp = o;
        q.push_back(v);
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'h23:        return 3'd1;
            7'h63:        return 3'd2;
            7'h37, 7'h17: return 3'd3;
            7'h6F:        return 3'd4;
            default:      return 3'd0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        case (op)
            7'h03, 7'h23, 7'h33, 7'h3B, 7'h13, 7'h1B, 7'h37, 7'h17,
            7'h63, 7'h6F, 7'h67, 7'h0F, 7'h73: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic outs_t fetch_o();
        outs_t o = '0;
        o.mem_req = 1'b1; o.src_b = 2'd2; o.res = 2'd2;
        return o;
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction: fw fetch waits,
    // mw memory waits, hc cycles observed in HALT.
    task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input logic tk,
                             input int fw, input int mw, input int hc);
        outs_t o;
        logic [2:0] im;
        im = imm_of(op);
        for (int i = 0; i < fw; i++) push(op, f3, 1'b0, tk, fetch_o());
        o = fetch_o(); o.ir_write = 1'b1; o.pc_write = 1'b1;
        push(op, f3, 1'b1, tk, o);
        o = '0; o.src_a = 2'd1; o.src_b = 2'd1; o.imm = 3'd2;
        push(op, f3, 1'($urandom), tk, o);
        o = '0; o.imm = im;
        case (op)
            7'h33, 7'h3B, 7'h13, 7'h1B, 7'h37, 7'h17, 7'h6F: begin
                if (op == 7'h33 || op == 7'h3B) begin
                    o.src_a = 2'd2; o.alu_op = 2'd2; o.word = (op == 7'h3B);
                end else if (op == 7'h13 || op == 7'h1B) begin
                    o.src_a = 2'd2; o.src_b = 2'd1; o.alu_op = 2'd2; o.word = (op == 7'h1B);
                end else if (op == 7'h37) begin
                    o.src_b = 2'd1; o.alu_op = 2'd3;
                end else if (op == 7'h17) begin
                    o.src_a = 2'd1; o.src_b = 2'd1;
                end else begin
                    o.src_a = 2'd1; o.src_b = 2'd2; o.pc_write = 1'b1;
                end
                push(op, f3, 1'($urandom), tk, o);
                o = '0; o.imm = im; o.rwe = 1'b1;
                push(op, f3, 1'($urandom), tk, o);
            end
            7'h03, 7'h23: begin
                o.src_a = 2'd2; o.src_b = 2'd1;
                push(op, f3, 1'($urandom), tk, o);
                o = '0; o.imm = im; o.mem_req = 1'b1; o.adr_src = 1'b1; o.msize = f3[1:0];
                if (op == 7'h03) o.muns = f3[2];
                else o.mem_write_en = 1'b1;
                for (int i = 0; i < mw; i++) push(op, f3, 1'b0, tk, o);
                push(op, f3, 1'b1, tk, o);
                if (op == 7'h03) begin
                    o = '0; o.imm = im; o.res = 2'd1; o.rwe = 1'b1;
                    o.msize = f3[1:0]; o.muns = f3[2];
                    push(op, f3, 1'($urandom), tk, o);
                end
            end
            7'h63: begin
                o.src_a = 2'd2; o.alu_op = 2'd1; o.pc_write = tk;
                push(op, f3, 1'($urandom), tk, o);
            end
            7'h67: begin
                o.src_a = 2'd2; o.src_b = 2'd1; o.res = 2'd2; o.pc_write = 1'b1;
                push(op, f3, 1'($urandom), tk, o);
                o = '0; o.imm = im; o.src_a = 2'd1; o.src_b = 2'd2; o.res = 2'd2; o.rwe = 1'b1;
                push(op, f3, 1'($urandom), tk, o);
            end
            7'h0F: ;
            default: begin
                o = '0; o.halted = 1'b1; o.illegal = (op != 7'h73);
                for (int i = 0; i < hc; i++) push(op, f3, 1'($urandom), tk, o);
            end
        endcase
    endtask

    task automatic push_rw();
        for (int i = 0; i < RWC; i++) push(7'($urandom), 3'($urandom), 1'($urandom), 1'b0, '0);
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_q(input string nm);
        for (int i = 0; i < q.size(); i++) begin
            opcode = q[i].op; funct3 = q[i].f3; mem_ready = q[i].rdy;
            branch_taken = q[i].tk; funct7_bit5 = 1'($urandom);
            @(negedge clk);
            check($sformatf("%s[%0d]", nm, i), q[i].exp);
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b1; #1;
        rst_n = 1'b0; mem_ready = 1'b1; #2;
        check("reset_outputs", '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t  tbl[6];
        outs_t o;
        logic [6:0] rop;

        for (int i = 0; i < 6; i++) begin
            tbl[i].op = 7'h33; tbl[i].f3 = 3'd0; tbl[i].rdy = 1'b1;
            tbl[i].tk = 1'b0; tbl[i].exp = '0;
        end
        tbl[1].exp.mem_req = 1'b1; tbl[1].exp.src_b = 2'd2; tbl[1].exp.res = 2'd2;
        tbl[1].exp.ir_write = 1'b1; tbl[1].exp.pc_write = 1'b1;
        tbl[2].exp.src_a = 2'd1; tbl[2].exp.src_b = 2'd1; tbl[2].exp.imm = 3'd2;
        tbl[3].exp.src_a = 2'd2; tbl[3].exp.alu_op = 2'd2;
        tbl[4].exp.rwe = 1'b1;
        tbl[5].exp = tbl[1].exp;

        do_reset();
        for (int i = 0; i < 6; i++) q.push_back(tbl[i]);
        run_q("add_table");

        do_reset(); push_rw();
        add_instr(7'h03, 3'b010, 1'b0, 0, 3, 0);
        run_q("lw_wait3");

        do_reset(); push_rw();
        add_instr(7'h63, 3'b000, 1'b1, 0, 0, 0);
        add_instr(7'h63, 3'b000, 1'b0, 0, 0, 0);
        add_instr(7'h67, 3'b000, 1'b0, 0, 0, 0);
        add_instr(7'h7F, 3'b000, 1'b0, 0, 0, 20);
        run_q("beq_jalr_illegal");

        do_reset(); push_rw();
        add_instr(7'h73, 3'b000, 1'b0, 1, 0, 5);
        run_q("ecall");

        do_reset(); push_rw();
        add_instr(7'h23, 3'b001, 1'b0, 0, 2, 0);
        void'(q.pop_back());
        run_q("sh_pending");
        o = '0; o.mem_req = 1'b1; o.mem_write_en = 1'b1; o.adr_src = 1'b1;
        o.msize = 2'b01; o.imm = 3'd1;
        check("sh_still_waiting", o);
        #2 rst_n = 1'b0; mem_ready = 1'b1;
        #1 check("async_drop", '0);
        @(posedge clk); #1;
        check("held_in_reset", '0);
        rst_n = 1'b1;
        push_rw();
        add_instr(7'h33, 3'b000, 1'b0, 0, 0, 0);
        run_q("after_reset");

        for (int p = 0; p < 8; p++) begin
            do_reset(); push_rw();
            for (int k = 0; k < int'($urandom_range(10, 4)); k++) begin
                do rop = 7'($urandom); while (!is_legal(rop) || rop == 7'h73);
                add_instr(rop, 3'($urandom), 1'($urandom), int'($urandom_range(2, 0)),
                          int'($urandom_range(3, 0)), 0);
            end
            if ($urandom_range(1, 0) == 1) begin
                if ($urandom_range(1, 0) == 1) rop = 7'h73;
                else do rop = 7'($urandom); while (is_legal(rop));
                add_instr(rop, 3'($urandom), 1'b0, 0, 0, 4);
            end
            run_q($sformatf("rand%0d", p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
